mem_stall_ctrl: RTL and testbench
=================================

Name: mem_stall_ctrl

Overview:
- Pipeline stall/sequencing controller for the 5-stage MIPS core with the L1 data cache backed by L2.
- Generates the write enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, including the MEM/WB register's MEMWBWrite.
- Freezes the whole pipeline on an L1 data miss, runs the L2 request/ack handshake and the L1 fill cycle, then releases the pipeline.
- Also detects load-use hazards and inserts an ID/EX bubble.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_req  in  1  the MEM-stage instruction performs a data-memory access.
- mem_hit  in  1  L1 data-cache hit for the current MEM access.
- l2_ack  in  1  one-cycle pulse: L2 refill data valid.
- idex_memread  in  1  the ID/EX instruction is a load.
- idex_rt  in  REG_W  load destination in ID/EX.
- ifid_rs  in  REG_W  source register of the IF/ID instruction.
- ifid_rt  in  REG_W  source register of the IF/ID instruction.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEXWrite  out  1  ID/EX register enable.
- idex_bubble  out  1  zero the control fields loaded into ID/EX.
- EXMEMWrite  out  1  EX/MEM register enable.
- MEMWBWrite  out  1  MEM/WB register enable.
- l2_req  out  1  L2 refill request, registered.
- fill_we  out  1  L1 line write strobe, registered.
- stall_cycles  out  CNT_W  stall-cycle counter.

Behaviour:
- Clock and reset:
  - One clock domain (clock).
  - rst is asynchronous and active-high.
  - Reset forces state = RUN, l2_req = 0, fill_we = 0, stall_cycles = 0.
- FSM states:
  - RUN: normal operation.
  - MISS: l2_req = 1, waiting for l2_ack.
  - FILL: fill_we = 1 for exactly one cycle.
- Registered outputs:
  - l2_req = (state == MISS).
  - fill_we = (state == FILL).
  - Both are Moore outputs.
- Miss condition: miss = (state == RUN) & mem_req & !mem_hit.
- Freeze condition: freeze = miss | (state != RUN).
- While freeze is high:
  - PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite and MEMWBWrite are all 0, in the same cycle the miss is seen (zero-latency freeze).
  - idex_bubble = 0.
- Load-use hazard (evaluated only when freeze = 0):
  - Hazard = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt)).
  - On hazard: PCWrite = 0, IFIDWrite = 0, IDEXWrite = 1, idex_bubble = 1, EXMEMWrite = 1, MEMWBWrite = 1.
- Otherwise all enables = 1 and idex_bubble = 0.
- Enables are combinational from state and inputs; under rst they follow RUN rules.
- Transitions:
  - RUN -> MISS on miss.
  - MISS -> FILL on l2_ack.
  - MISS holds indefinitely without l2_ack.
  - FILL -> RUN unconditionally.
- l2_ack outside MISS is ignored.
- Minimum miss freeze is 3 cycles: the miss cycle, MISS (with ack in its first cycle), and FILL.
- Replay: on return to RUN, the held MEM access is re-evaluated.
  - If mem_hit = 1, the pipeline advances.
  - If mem_hit = 0 again, the controller re-enters MISS (no special case).
- Miss and load-use hazard in the same cycle: the miss wins; no bubble that cycle.
  - The hazard is re-evaluated after release, because IF/ID and ID/EX were held.
- rst asserted in MISS or FILL:
  - Immediate return to RUN.
  - l2_req and fill_we drop asynchronously.
  - The outstanding L2 transaction is abandoned; the L2 side is reset by the same rst.

Optional Feature:
- Macro: MEM_STALL_CNT_EN.
- Defined:
  - stall_cycles increments on every rising edge where PCWrite = 0 (miss freeze or load-use stall).
  - It saturates at all-ones and never wraps.
  - It is cleared only by rst.
- Not defined: stall_cycles is tied to 0 and no counter logic is present.

Test Plan:
- Load-use hazard: idex_memread = 1, idex_rt = 5, ifid_rs = 5, no miss.
  - Same cycle: PCWrite = 0, IFIDWrite = 0, idex_bubble = 1, IDEXWrite = EXMEMWrite = MEMWBWrite = 1.
  - Repeat with idex_rt = 0: no stall.
- Miss with ack after 4 MISS cycles: mem_req = 1, mem_hit = 0 in cycle t, l2_ack pulsed in the 4th MISS cycle.
  - All enables 0 from t.
  - l2_req = 1 for cycles t+1..t+4.
  - fill_we = 1 at t+5.
  - At t+6 with mem_hit = 1: all enables = 1.
- Simultaneous events: miss and load-use hazard in the same cycle.
  - Enables all 0 and idex_bubble = 0.
  - After release, one bubble cycle follows.
- Stray l2_ack in RUN: ignored; state stays RUN and no fill_we.
- Reset mid-miss: rst asserted while in MISS.
  - l2_req = 0 immediately, state RUN, enables 1 once mem_req = 0.
- With MEM_STALL_CNT_EN and CNT_W = 4, force a 20-cycle freeze: stall_cycles = 15 (saturated).
- Without MEM_STALL_CNT_EN: stall_cycles = 0 throughout.

Source files
------------

// File: rtl/mem_stall_ctrl_if.sv
// mem_stall_ctrl_if: pipeline-side signal bundle of the stall/sequencing controller
// master: controller side (drives enables, bubble, L2/L1 strobes, stall counter)
// slave:  pipeline/memory side (drives MEM access status, L2 ack, hazard operands)
interface mem_stall_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             mem_req;
    logic             mem_hit;
    logic             l2_ack;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEXWrite;
    logic             idex_bubble;
    logic             EXMEMWrite;
    logic             MEMWBWrite;
    logic             l2_req;
    logic             fill_we;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  mem_req, mem_hit, l2_ack, idex_memread, idex_rt, ifid_rs, ifid_rt,
        output PCWrite, IFIDWrite, IDEXWrite, idex_bubble, EXMEMWrite, MEMWBWrite,
               l2_req, fill_we, stall_cycles
    );

    modport slave (
        output mem_req, mem_hit, l2_ack, idex_memread, idex_rt, ifid_rs, ifid_rt,
        input  PCWrite, IFIDWrite, IDEXWrite, idex_bubble, EXMEMWrite, MEMWBWrite,
               l2_req, fill_we, stall_cycles
    );
endinterface

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: 5-stage pipeline stall controller (L1 miss freeze + L2 refill, load-use bubble)
// Ports: clock, rst (async, active-high), bus (mem_stall_ctrl_if.master)
// Optional: define MEM_STALL_CNT_EN to enable the saturating stall_cycles counter
module mem_stall_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic             clock,
    input logic             rst,
    mem_stall_ctrl_if.master bus
);
    typedef enum logic [1:0] {RUN, MISS, FILL} state_t;
    state_t           state, state_nx;
    logic             miss, freeze, hazard, l2_req_q, fill_we_q;
    logic [REG_W-1:0] rt;

    assign rt     = bus.idex_rt;
    assign miss   = (state == RUN) && bus.mem_req && !bus.mem_hit;
    assign freeze = miss || (state != RUN);
    // Register 0 is never a real dependency, so a load to it cannot cause a stall.
    assign hazard = bus.idex_memread && (rt != '0) && ((rt == bus.ifid_rs) || (rt == bus.ifid_rt));

    always_comb begin
        state_nx = (state == RUN)  ? (miss ? MISS : RUN) :
                   (state == MISS) ? (bus.l2_ack ? FILL : MISS) : RUN;
    end

    // l2_req/fill_we are flopped from the next state so they are clean Moore outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            l2_req_q  <= 1'b0;
            fill_we_q <= 1'b0;
        end else begin
            state     <= state_nx;
            l2_req_q  <= (state_nx == MISS);
            fill_we_q <= (state_nx == FILL);
        end
    end

    // A miss freeze dominates a load-use hazard; the hazard is seen again after release.
    assign bus.PCWrite     = !freeze && !hazard;
    assign bus.IFIDWrite   = !freeze && !hazard;
    assign bus.IDEXWrite   = !freeze;
    assign bus.idex_bubble = !freeze && hazard;
    assign bus.EXMEMWrite  = !freeze;
    assign bus.MEMWBWrite  = !freeze;
    assign bus.l2_req      = l2_req_q;
    assign bus.fill_we     = fill_we_q;

`ifdef MEM_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!bus.PCWrite && !(&cnt))
            cnt <= cnt + 1'b1;
    end
    assign bus.stall_cycles = cnt;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed scoreboard bench for mem_stall_ctrl
module tb_mem_stall_ctrl;
`ifdef MEM_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    // Expected vector bits: {PCWrite, IFIDWrite, IDEXWrite, idex_bubble, EXMEMWrite, MEMWBWrite, l2_req, fill_we}
    localparam logic [7:0] RUNV = 8'hEC;
    localparam logic [7:0] HAZV = 8'h3C;
    localparam logic [7:0] FRZV = 8'h00;
    localparam logic [7:0] MISV = 8'h02;
    localparam logic [7:0] FILV = 8'h01;

    typedef struct {
        string      nm;
        logic [7:0] exp;
        logic [3:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    logic [3:0] stalls = 4'd0;
    bit   prev_rst = 1'b1;
    bit   prev_pcw = 1'b1;

    mem_stall_ctrl_if #(.REG_W(5), .CNT_W(4)) bus();
    mem_stall_ctrl #(.REG_W(5), .CNT_W(4)) dut (.clock(clock), .rst(rst), .bus(bus));

    always #5 clock = ~clock;

    initial begin
        bus.mem_req = 0; bus.mem_hit = 0; bus.l2_ack = 0; bus.idex_memread = 0;
        bus.idex_rt = 0; bus.ifid_rs = 0; bus.ifid_rt = 0;
    end

    always @(negedge clock) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [7:0] got;
            e = q.pop_front();
            got = {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.idex_bubble,
                   bus.EXMEMWrite, bus.MEMWBWrite, bus.l2_req, bus.fill_we};
            n_chk++;
            if (got !== e.exp) begin
                n_bad++;
                $display("FAIL %s: outputs got %b expected %b", e.nm, got, e.exp);
            end
            n_chk++;
            if (bus.stall_cycles !== e.cnt) begin
                n_bad++;
                $display("FAIL %s_cnt: stall_cycles got %0d expected %0d", e.nm, bus.stall_cycles, e.cnt);
            end
        end
    end

    task automatic drive(input string nm, input bit r, input bit req, input bit hit, input bit ack,
                         input bit mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] frt, input logic [7:0] exp);
        @(posedge clock);
        #1;
        if (!prev_rst && !prev_pcw && stalls != 4'hF) stalls++;
        rst = r;
        bus.mem_req = req; bus.mem_hit = hit; bus.l2_ack = ack;
        bus.idex_memread = mr; bus.idex_rt = rt; bus.ifid_rs = rs; bus.ifid_rt = frt;
        if (r) stalls = 4'd0;
        q.push_back('{nm, exp, CNT_EN ? stalls : 4'd0});
        prev_rst = r;
        prev_pcw = exp[7];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive("reset",       1, 0, 0, 0, 0, 0, 0, 0, RUNV);
        drive("idle",        0, 0, 0, 0, 0, 0, 0, 0, RUNV);
        drive("loaduse_rs",  0, 0, 0, 0, 1, 5, 5, 0, HAZV);
        drive("loaduse_rt",  0, 0, 0, 0, 1, 5, 3, 5, HAZV);
        drive("rt_zero",     0, 0, 0, 0, 1, 0, 0, 0, RUNV);
        drive("no_match",    0, 0, 0, 0, 1, 5, 6, 7, RUNV);
        drive("no_memread",  0, 0, 0, 0, 0, 5, 5, 5, RUNV);
        drive("hit",         0, 1, 1, 0, 0, 0, 0, 0, RUNV);
        drive("miss_t",      0, 1, 0, 0, 0, 0, 0, 0, FRZV);
        drive("miss_t1",     0, 1, 0, 0, 0, 0, 0, 0, MISV);
        drive("miss_t2",     0, 1, 0, 0, 0, 0, 0, 0, MISV);
        drive("miss_t3",     0, 1, 0, 0, 0, 0, 0, 0, MISV);
        drive("miss_t4_ack", 0, 1, 0, 1, 0, 0, 0, 0, MISV);
        drive("fill_t5",     0, 1, 0, 0, 0, 0, 0, 0, FILV);
        drive("replay_hit",  0, 1, 1, 0, 0, 0, 0, 0, RUNV);
        drive("min_miss",    0, 1, 0, 0, 0, 0, 0, 0, FRZV);
        drive("min_ack",     0, 1, 0, 1, 0, 0, 0, 0, MISV);
        drive("min_fill",    0, 1, 0, 0, 0, 0, 0, 0, FILV);
        drive("replay_miss", 0, 1, 0, 0, 0, 0, 0, 0, FRZV);
        drive("re_ack",      0, 1, 0, 1, 0, 0, 0, 0, MISV);
        drive("re_fill",     0, 1, 0, 0, 0, 0, 0, 0, FILV);
        drive("re_hit",      0, 1, 1, 0, 0, 0, 0, 0, RUNV);
        drive("miss_haz",    0, 1, 0, 0, 1, 5, 5, 0, FRZV);
        drive("haz_miss",    0, 1, 0, 1, 1, 5, 5, 0, MISV);
        drive("haz_fill",    0, 1, 0, 0, 1, 5, 5, 0, FILV);
        drive("haz_release", 0, 1, 1, 0, 1, 5, 5, 0, HAZV);
        drive("haz_after",   0, 1, 1, 0, 0, 0, 0, 0, RUNV);
        drive("stray_ack",   0, 0, 0, 1, 0, 0, 0, 0, RUNV);
        drive("post_stray",  0, 0, 0, 0, 0, 0, 0, 0, RUNV);
        drive("rmiss",       0, 1, 0, 0, 0, 0, 0, 0, FRZV);
        drive("rmiss_wait",  0, 1, 0, 0, 0, 0, 0, 0, MISV);
        drive("rst_in_miss", 1, 0, 0, 0, 0, 0, 0, 0, RUNV);
        drive("post_rst",    0, 0, 0, 0, 0, 0, 0, 0, RUNV);
        drive("long_miss",   0, 1, 0, 0, 0, 0, 0, 0, FRZV);
        for (int i = 0; i < 18; i++)
            drive("long_wait", 0, 1, 0, 0, 0, 0, 0, 0, MISV);
        drive("long_ack",    0, 1, 0, 1, 0, 0, 0, 0, MISV);
        drive("long_fill",   0, 1, 0, 0, 0, 0, 0, 0, FILV);
        drive("long_rel",    0, 1, 1, 0, 0, 0, 0, 0, RUNV);
        drive("sat_hold",    0, 0, 0, 0, 0, 0, 0, 0, RUNV);
        for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clock);
        n_chk++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d pending expected entries, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_bad);
        $finish;
    end
endmodule
